// File: rtl/button_event_decoder_if.sv
// Button level in, single-cycle event strobes out, between the debouncer
// and the stopwatch control FSM.
interface button_event_decoder_if;
    logic button_state;
    logic repeat_en;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output button_state, repeat_en,
        input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
    );

    modport slave (
        input  button_state, repeat_en,
        output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/long/repeat strobes.
// Every output is registered and changes on the same edge as the state.
module button_event_decoder #(
    parameter int unsigned CNT_W         = 27,
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_event_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             armed;
    logic             press_q, release_q, click_q, long_q, repeat_q, held_q;
    logic             press_nxt, release_nxt, click_nxt, long_nxt, repeat_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            armed     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            // A button held through reset must be seen released once before it counts.
            armed     <= armed | ~bus.button_state;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            click_q   <= click_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
            held_q    <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && bus.button_state) begin
                    state_nxt = SHORT;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            SHORT: begin
                // Release wins over the long threshold on the same edge.
                if (!bus.button_state) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    click_nxt   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG: begin
                if (!bus.button_state) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_nxt    = '0;
                    repeat_nxt = bus.repeat_en;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.click_pulse   = click_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the debounced button level produced by the stopwatch's button conditioning stage into single-cycle event pulses: press, release, short click, long-press, and auto-repeat. It sits between the debouncer output and the stopwatch control FSM. Control logic therefore consumes clean one-cycle strobes instead of raw levels. All timing is in `clk` cycles; no pulses are lost or duplicated regardless of how long the button is held.

## Interface
- `CNT_W`, 27: hold-counter width in bits.
- `LONG_CYCLES`, 50_000_000: cycles the button must stay held after press before `long_pulse` (0.5 s at 100 MHz). Must be ≥ 2 and < 2^CNT_W.
- `REPEAT_CYCLES`, 10_000_000: auto-repeat period once long-press is reached (0.1 s at 100 MHz). Must be ≥ 1 and < 2^CNT_W.
- `clk  input  1`: system clock, rising-edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `button_state  input  1`: debounced level, 1 = pressed. Synchronous to `clk`.
- `repeat_en  input  1`: 1 enables `repeat_pulse` generation in LONG state.
- `press_pulse  output  1`: one-cycle strobe on accepted press.
- `release_pulse  output  1`: one-cycle strobe on any release after an accepted press.
- `click_pulse  output  1`: one-cycle strobe on release before long-press threshold.
- `long_pulse  output  1`: one-cycle strobe when hold reaches `LONG_CYCLES`.
- `repeat_pulse  output  1`: one-cycle strobe every `REPEAT_CYCLES` while in LONG and `repeat_en`=1.
- `held  output  1`: 1 while state ≠ IDLE.

## Operation
- Registers: `state` (IDLE, SHORT, LONG), `cnt[CNT_W-1:0]`, `armed`, and all outputs. All outputs are registered and updated on the same edge as the state transition.
- `armed`:
  - Reset value 0.
  - Set on any edge where `button_state`=0.
  - Never cleared except by reset.
  - A button held through reset release produces no events until it is released once.
- IDLE:
  - If `armed`=1 (current value) and `button_state`=1, go to SHORT, set `cnt`=0, and pulse `press_pulse`.
  - Otherwise stay in IDLE.
- SHORT:
  - `button_state`=0: go to IDLE and pulse `release_pulse` and `click_pulse` together.
  - Else if `cnt`==`LONG_CYCLES`-1: go to LONG, set `cnt`=0, and pulse `long_pulse`.
  - Else `cnt`+1.
- LONG:
  - `button_state`=0: go to IDLE and pulse `release_pulse` only.
  - Else if `cnt`==`REPEAT_CYCLES`-1: set `cnt`=0 and pulse `repeat_pulse` if `repeat_en`=1 (the counter still wraps when `repeat_en`=0).
  - Else `cnt`+1.
- Release has priority over threshold when both occur on the same edge.
- Pulse exclusivity: at most one of press/long/repeat/release per cycle. `click_pulse` only ever coincides with `release_pulse`.
- `cnt` never exceeds its threshold-1, so no wrap of the `CNT_W`-bit counter is possible.
- `held` = registered (next_state ≠ IDLE).

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): `state`=IDLE, `cnt`=0, `armed`=0, all outputs 0.
- `button_state` sampled 1 at edge E0 (armed): `press_pulse`=1 and `held`=1 for the cycle after E0.
- Held continuously: `long_pulse` in the cycle after edge E0+`LONG_CYCLES`. The k-th `repeat_pulse` follows the edge at E0+`LONG_CYCLES`+k·`REPEAT_CYCLES`.
- `button_state` first sampled 0 at edge Er: `release_pulse` (plus `click_pulse` if in SHORT) in the cycle after Er, and `held`=0 from the same edge.
- Minimum press: high at E0 and low at E1 gives press, then release+click on consecutive cycles.
- Re-press at the edge immediately after release (IDLE with `button_state`=1) gives a new `press_pulse` one cycle after the release pulses. No dead time is inserted.
- `rst_n` asserted mid-hold clears all pulses and `held` immediately (asynchronously), with no release event emitted.

## Test plan
- Params LONG=8, REPEAT=3, `repeat_en`=1. Reset, `button_state`=0 for 2 cycles, high for 4 cycles, then low: `press_pulse` 1 cycle; 4 cycles later `release_pulse`+`click_pulse` together; `long_pulse` never asserted.
- Same params, hold 20 cycles: `press_pulse` at t, `long_pulse` at t+8, `repeat_pulse` at t+11, t+14, t+17, t+20 if still held; then `release_pulse` without `click_pulse`.
- `repeat_en`=0, hold 20 cycles: `long_pulse` at t+8; no `repeat_pulse`; `held`=1 throughout; single `release_pulse`.
- `button_state`=1 during and after reset release for 10 cycles, then 0 for 1 cycle, then 1: no events before the low; `press_pulse` exactly one cycle after the second rising sample.
- Release on the same edge `cnt` reaches LONG-1 (held exactly 8 samples, low on the 9th): `release_pulse`+`click_pulse` and no `long_pulse`. Also assert `rst_n`=0 at t+10 during a hold: all outputs 0 immediately, with no `release_pulse`.
